// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver that deframes start/data/stop frames from rx into bytes.
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   s_tick       in   oversample tick (OVS per bit period), 1-clk pulse
//   rx           in   serial line, asynchronous, idles high
//   dout         out  last received byte (DBIT bits)
//   rx_done_tick out  1-clk pulse when dout/frame_err have been updated
//   frame_err    out  stop bit was sampled low on the last frame
//   busy         out  receiver is inside a frame (state != IDLE)
module uart_rx_core #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);
    localparam int SW = $clog2(OVS > SB_TICK ? OVS : SB_TICK);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] HALF_M1 = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_M1  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_M1 = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_N  = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [SW-1:0]   s_cnt_q;
    logic [NW-1:0]   n_cnt_q;
    logic [DBIT-1:0] b_q;
    logic [1:0]      sync_q;
    logic            rx_s;

    assign rx_s = sync_q[1];
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            b_q          <= '0;
            sync_q       <= 2'b11;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            rx_done_tick <= 1'b0;
            case (state_q)
                IDLE: begin
                    // start edge is watched every clock so no tick phase is lost
                    if (!rx_s) begin
                        state_q <= START;
                        s_cnt_q <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt_q == HALF_M1) begin
                            // mid start bit: still low means a real frame, else a glitch
                            if (!rx_s) begin
                                state_q <= DATA;
                                s_cnt_q <= '0;
                                n_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt_q == BIT_M1) begin
                            s_cnt_q <= '0;
                            b_q     <= {rx_s, b_q[DBIT-1:1]};
                            if (n_cnt_q == LAST_N) state_q <= STOP;
                            else n_cnt_q <= n_cnt_q + NW'(1);
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt_q == STOP_M1) begin
                            // byte is delivered even on a framing error
                            state_q      <= IDLE;
                            dout         <= b_q;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames checked against a queue-based frame model.
module tb_uart_rx_core;
    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int   nchk = 0;
    int   nfail = 0;
    logic tick_en = 1'b1;
    int   tcnt = 0;
    logic prev_done = 1'b0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    uart_rx_core dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
        .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt   = (tcnt + 1) % 4;
        s_tick = tick_en && (tcnt == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_tick) begin
            chk("no_double_pulse", 32'(prev_done), 32'd0);
            got_q.push_back({frame_err, dout});
        end
        prev_done = rx_done_tick;
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!s_tick && guard < 2000);
            if (guard >= 2000) begin
                $display("FAIL tick_timeout observed=none expected=s_tick");
                $fatal(1, "tick timeout");
            end
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_ticks(n);
    endtask

    // a bad stop bit is released early so the line is high before the receiver re-arms
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        drive_bit(1'b0, BT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BT);
        if (stop_ok) begin
            drive_bit(1'b1, BT);
        end else begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, 4 + BT);
        end
        exp_q.push_back({~stop_ok, d});
    endtask

    task automatic check_frames(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [8:0] e = exp_q.pop_front();
            logic [8:0] g = got_q.pop_front();
            chk({tag, "_dout"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] pd;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_done", 32'(rx_done_tick), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_ticks(20);

        send_frame(8'h55, 1'b1);
        check_frames("f55");
        wait_ticks(BT);
        chk("idle_busy_after_55", 32'(busy), 32'd0);

        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        check_frames("b2b");

        drive_bit(1'b0, 5);
        drive_bit(1'b1, 30);
        chk("glitch_pulses", 32'(got_q.size()), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_dout", 32'(dout), 32'h3C);

        send_frame(8'hF0, 1'b0);
        check_frames("ferr");
        send_frame(8'h0F, 1'b1);
        check_frames("ferr_clear");

        pd = 8'hC6;
        drive_bit(1'b0, BT);
        for (int i = 0; i < 3; i++) drive_bit(pd[i], BT);
        drive_bit(pd[3], 8);
        rst = 1'b0;
        rx  = 1'b1;
        #2;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(rx_done_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ticks(BT);
        chk("mid_rst_pulses", 32'(got_q.size()), 32'd0);
        send_frame(8'h81, 1'b1);
        check_frames("after_rst");

        fork
            send_frame(8'h5A, 1'b1);
            begin
                wait_ticks(BT * 4 + 5);
                tick_en = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                chk("freeze_busy", 32'(busy), 32'd1);
                chk("freeze_pulses", 32'(got_q.size()), 32'd0);
                tick_en = 1'b1;
            end
        join
        check_frames("freeze");

        for (int k = 0; k < 10; k++) begin
            logic [7:0] d  = 8'($urandom);
            logic       ok = ($urandom_range(0, 3) != 0);
            send_frame(d, ok);
            if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 20));
        end
        check_frames("rand");
        wait_ticks(BT);
        chk("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
